// File: rtl/morse_pkg.sv
// morse_pkg: shared types and tables for the Morse letter link.
// Macro MORSE_DEC_SYNC_EN is consumed by morse_decoder.
package morse_pkg;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    localparam logic [2:0] DOT      = 3'd1;
    localparam logic [2:0] DASH     = 3'd3;
    localparam logic [2:0] EOC      = 3'd3;
    localparam logic [2:0] MAX_ELEM = 3'd4;
    localparam logic [2:0] RUN_SAT  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [2:0] n;
        logic [3:0] elem;
    } pattern_t;

    // element count and dot(0)/dash(1) pattern, first element in bit 0
    function automatic pattern_t letter_pattern(input logic [2:0] code);
        pattern_t p;
        p = '0;
        case (code)
            LTR_A: p = '{n: 3'd2, elem: 4'b0010};
            LTR_B: p = '{n: 3'd4, elem: 4'b0001};
            LTR_C: p = '{n: 3'd4, elem: 4'b0101};
            LTR_D: p = '{n: 3'd3, elem: 4'b0001};
            LTR_E: p = '{n: 3'd1, elem: 4'b0000};
            LTR_F: p = '{n: 3'd4, elem: 4'b0100};
            LTR_G: p = '{n: 3'd3, elem: 4'b0011};
            LTR_H: p = '{n: 3'd4, elem: 4'b0000};
            default: p = '0;
        endcase
        return p;
    endfunction

    // returns {hit, code}; hit=0 when no letter matches
    function automatic logic [3:0] morse_decode(
        input logic [2:0] n,
        input logic [3:0] elem
    );
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (letter_pattern(3'(i)) == {n, elem}) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// morse_tick_gen: unit-time tick, one pulse every DIV_COUNT+1 clocks.
// Shared by the Morse transmitter and receiver.
module morse_tick_gen #(
    parameter logic [27:0] DIV_COUNT = 28'h17D783F
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [27:0] count;

    // down-counter, reloads after reaching zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= DIV_COUNT;
        end else if (count == '0) begin
            count <= DIV_COUNT;
        end else begin
            count <= count - 28'd1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: run-length Morse receiver for letters A..H.
// Define MORSE_DEC_SYNC_EN to add a 2-flop input synchronizer.
module morse_decoder #(
    parameter logic [27:0] DIV_COUNT = 28'h17D783F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    import morse_pkg::*;

    logic       tick_raw;
    logic       tick;
    logic       line;
    state_t     state;
    logic [2:0] run;
    logic [2:0] n;
    logic [3:0] elem;
    logic       dec_hit;
    logic [2:0] dec_code;

    morse_tick_gen #(
        .DIV_COUNT(DIV_COUNT)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick_raw)
    );

`ifdef MORSE_DEC_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] tick_q;

    // synchronize the line; tick is delayed alongside so sampling stays aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            tick_q <= '0;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            tick_q <= {tick_q[0], tick_raw};
        end
    end

    assign line = sync_q[1];
    assign tick = tick_q[1];
`else
    assign line = serial_in;
    assign tick = tick_raw;
`endif

    assign {dec_hit, dec_code} = morse_decode(n, elem);
    assign busy = (state != IDLE);

    // run-length FSM: collects elements, decodes on end-of-character space
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            run    <= '0;
            n      <= '0;
            elem   <= '0;
            letter <= '0;
            valid  <= 1'b0;
            error  <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (line) begin
                            state <= MARK;
                            run   <= DOT;
                            n     <= '0;
                            elem  <= '0;
                        end
                    end
                    MARK: begin
                        if (line) begin
                            if (run != RUN_SAT) run <= run + 3'd1;
                        end else if (run == DOT || run == DASH) begin
                            if (n == MAX_ELEM) begin
                                error <= 1'b1;
                                state <= FLUSH;
                                run   <= 3'd1;
                            end else begin
                                elem[n[1:0]] <= (run == DASH);
                                n     <= n + 3'd1;
                                state <= SPACE;
                                run   <= 3'd1;
                            end
                        end else begin
                            error <= 1'b1;
                            state <= FLUSH;
                            run   <= 3'd1;
                        end
                    end
                    SPACE: begin
                        if (line) begin
                            if (run == 3'd1) begin
                                state <= MARK;
                                run   <= DOT;
                            end else begin
                                error <= 1'b1;
                                state <= FLUSH;
                                run   <= '0;
                            end
                        end else if (run + 3'd1 == EOC) begin
                            if (dec_hit) begin
                                letter <= dec_code;
                                valid  <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                            state <= IDLE;
                            run   <= '0;
                        end else begin
                            run <= run + 3'd1;
                        end
                    end
                    FLUSH: begin
                        if (line) begin
                            run <= '0;
                        end else if (run + 3'd1 == EOC) begin
                            state <= IDLE;
                            run   <= '0;
                        end else begin
                            run <= run + 3'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed checks of the Morse receiver.
// One line bit per unit tick, LSB first, DIV_COUNT=3.
module tb_morse_decoder;

`ifdef MORSE_DEC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    morse_decoder #(
        .DIV_COUNT(28'd3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .serial_in(serial_in),
        .letter   (letter),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_val = 0;
    int n_err = 0;
    int n_both = 0;
    int vcyc = -1;
    int ecyc = -1;

    always @(negedge clock) begin
        if (valid) begin
            n_val <= n_val + 1;
            vcyc  <= cyc;
        end
        if (error) begin
            n_err <= n_err + 1;
            ecyc  <= cyc;
        end
        if (valid && error) n_both <= n_both + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int last_t = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (4) @(posedge clock);
        #1;
        last_t = cyc;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int len);
        for (int i = 0; i < len; i++) send_bit(bits[i]);
    endtask

    logic [15:0] pat [8];
    int          plen [8];
    int          v0;
    int          e0;
    int          t;

    initial begin
        pat[0] = 16'h001D; plen[0] = 8;
        pat[1] = 16'h0157; plen[1] = 12;
        pat[2] = 16'h05D7; plen[2] = 14;
        pat[3] = 16'h0057; plen[3] = 10;
        pat[4] = 16'h0001; plen[4] = 4;
        pat[5] = 16'h0175; plen[5] = 12;
        pat[6] = 16'h0177; plen[6] = 12;
        pat[7] = 16'h0055; plen[7] = 10;

        reset = 1'b1;
        serial_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_letter", letter, 0);
        chk("rst_valid", valid, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // A followed by a long idle space
        v0 = n_val; e0 = n_err;
        send_bits(pat[0], plen[0]);
        t = last_t;
        send_bits(16'h0, 6);
        chk("A_valid_cnt", n_val - v0, 1);
        chk("A_error_cnt", n_err - e0, 0);
        chk("A_letter", letter, 0);
        chk("A_valid_time", vcyc, t + LAT);

        // all eight letters back-to-back
        e0 = n_err;
        for (int i = 0; i < 8; i++) begin
            v0 = n_val;
            send_bits(pat[i], plen[i]);
            t = last_t;
            send_bit(1'b0);
            chk($sformatf("seq%0d_valid_cnt", i), n_val - v0, 1);
            chk($sformatf("seq%0d_letter", i), letter, i);
            chk($sformatf("seq%0d_valid_time", i), vcyc, t + LAT);
        end
        chk("seq_error_cnt", n_err - e0, 0);

        // 5-unit mark, flush, then E
        v0 = n_val; e0 = n_err;
        send_bits(16'h011F, 12);
        send_bit(1'b0);
        chk("long_error_cnt", n_err - e0, 1);
        chk("long_valid_cnt", n_val - v0, 1);
        chk("long_letter", letter, 4);

        // lone dash: no such letter
        v0 = n_val; e0 = n_err;
        send_bits(16'h0007, 6);
        send_bit(1'b0);
        chk("T_error_cnt", n_err - e0, 1);
        chk("T_valid_cnt", n_val - v0, 0);
        chk("T_letter_held", letter, 4);

        // 2-unit mark, flush with a restart, then D
        v0 = n_val; e0 = n_err;
        send_bits(16'h0003, 2);
        send_bit(1'b0);
        t = last_t;
        send_bit(1'b1);
        send_bits(16'h0, 2);
        chk("flush_busy", busy, 1);
        chk("flush_error_time", ecyc, t + LAT);
        send_bits(16'h0, 2);
        chk("flush_idle", busy, 0);
        chk("flush_error_cnt", n_err - e0, 1);
        send_bits(pat[3], plen[3]);
        t = last_t;
        send_bit(1'b0);
        chk("flushD_letter", letter, 3);
        chk("flushD_valid_cnt", n_val - v0, 1);
        chk("flushD_valid_time", vcyc, t + LAT);

        // reset in the middle of C
        send_bits(16'h0017, 6);
        chk("midC_busy", busy, 1);
        v0 = n_val; e0 = n_err;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_letter", letter, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_error", error, 0);
        chk("midrst_busy", busy, 0);
        reset = 1'b0;
        send_bits(pat[3], plen[3]);
        send_bit(1'b0);
        chk("rstD_letter", letter, 3);
        chk("rstD_valid_cnt", n_val - v0, 1);
        chk("rstD_error_cnt", n_err - e0, 0);

        chk("valid_error_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
